// File: rtl/cpu7_exu_wb_arb_pkg.sv
// cpu7_exu_wb_arb_pkg: shared constants and helpers for the integer writeback arbiter
package cpu7_exu_wb_arb_pkg;
  localparam int WB_GRLEN = 64;
  localparam int WB_STARVE_MAX_DEF = 4;
  localparam logic [4:0] REG_ZERO = 5'd0;
  function automatic logic [31:0] reg_mask(input logic [4:0] r);
    return (r == REG_ZERO) ? 32'd0 : 32'd1 << r;
  endfunction
endpackage

// File: rtl/cpu7_exu_wb_sb.sv
// cpu7_exu_wb_sb: pending-load scoreboard with RAW/WAW hazard lookup for decode
module cpu7_exu_wb_sb
  import cpu7_exu_wb_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        set_en,
  input  logic [4:0]  set_rd,
  input  logic        clr_en,
  input  logic [4:0]  clr_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic        rd_wen,
  output logic        hazard,
  output logic [31:0] pend
);
  // set is OR-ed after the clear so a same-cycle reissue keeps the bit owned
  always_ff @(posedge clk)
    if (reset) pend <= 32'd0;
    else pend <= (pend & ~(clr_en ? reg_mask(clr_rd) : 32'd0)) | (set_en ? reg_mask(set_rd) : 32'd0);
  assign hazard = pend[rs1] | pend[rs2] | (rd_wen & pend[rd]);
endmodule

// File: rtl/cpu7_exu_wb_arb.sv
// cpu7_exu_wb_arb: irf write-port arbiter (ALU over LSU), load scoreboard, starvation stall.
// Optional perf counters enabled by defining CPU7_WB_ARB_PERF_EN.
module cpu7_exu_wb_arb
  import cpu7_exu_wb_arb_pkg::*;
#(
  parameter int DW = WB_GRLEN,
  parameter int STARVE_MAX = WB_STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ecl_wb_wen_w,
  input  logic [4:0]    ecl_wb_rd_w,
  input  logic [DW-1:0] ecl_wb_data_w,
  input  logic          lsu_wb_valid,
  input  logic [4:0]    lsu_wb_rd,
  input  logic [DW-1:0] lsu_wb_data,
  output logic          wb_lsu_ready,
  input  logic          lsu_issue_valid_d,
  input  logic [4:0]    lsu_issue_rd_d,
  input  logic [4:0]    ifu_rs1_d,
  input  logic [4:0]    ifu_rs2_d,
  input  logic [4:0]    ifu_rd_d,
  input  logic          ifu_rf_wen_d,
  output logic          wb_ifu_stall_d,
  output logic          wb_irf_wen,
  output logic [4:0]    wb_irf_rd,
  output logic [DW-1:0] wb_irf_data
`ifdef CPU7_WB_ARB_PERF_EN
  ,
  output logic [31:0]   wb_perf_lsu_wait,
  output logic [31:0]   wb_perf_stall
`endif
);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  logic alu_sel, lsu_acc, lsu_wr, lsu_wait, hazard, starve;
  logic [3:0] starve_cnt, starve_nxt;
  logic [31:0] pend;
  assign alu_sel = ecl_wb_wen_w & (ecl_wb_rd_w != REG_ZERO);
  assign wb_lsu_ready = !reset & !alu_sel;
  assign lsu_acc = lsu_wb_valid & wb_lsu_ready;
  assign lsu_wr = lsu_acc & (lsu_wb_rd != REG_ZERO);
  assign lsu_wait = lsu_wb_valid & !wb_lsu_ready;
  assign starve_nxt = !lsu_wait ? 4'd0 : (starve_cnt == SMAX) ? SMAX : starve_cnt + 4'd1;
  assign starve = lsu_wait & (starve_nxt == SMAX);
  assign wb_ifu_stall_d = !reset & (hazard | starve);
  cpu7_exu_wb_sb u_sb (
    .clk    (clk),
    .reset  (reset),
    .set_en (lsu_issue_valid_d),
    .set_rd (lsu_issue_rd_d),
    .clr_en (lsu_acc),
    .clr_rd (lsu_wb_rd),
    .rs1    (ifu_rs1_d),
    .rs2    (ifu_rs2_d),
    .rd     (ifu_rd_d),
    .rd_wen (ifu_rf_wen_d),
    .hazard (hazard),
    .pend   (pend)
  );
  always_ff @(posedge clk)
    if (reset) begin
      wb_irf_wen <= 1'b0;
      wb_irf_rd <= REG_ZERO;
      wb_irf_data <= '0;
      starve_cnt <= 4'd0;
    end else begin
      wb_irf_wen <= alu_sel | lsu_wr;
      wb_irf_rd <= alu_sel ? ecl_wb_rd_w : lsu_wr ? lsu_wb_rd : REG_ZERO;
      wb_irf_data <= alu_sel ? ecl_wb_data_w : lsu_wr ? lsu_wb_data : '0;
      starve_cnt <= starve_nxt;
    end
`ifdef CPU7_WB_ARB_PERF_EN
  always_ff @(posedge clk)
    if (reset) begin
      wb_perf_lsu_wait <= 32'd0;
      wb_perf_stall <= 32'd0;
    end else begin
      wb_perf_lsu_wait <= wb_perf_lsu_wait + {31'd0, lsu_wait};
      wb_perf_stall <= wb_perf_stall + {31'd0, wb_ifu_stall_d};
    end
`endif
  // the ALU must never write a register still owned by an outstanding load
  ast_alu_vs_pend: assert property (@(posedge clk) disable iff (reset) !(alu_sel && pend[ecl_wb_rd_w]));
endmodule

// File: tb/tb_cpu7_exu_wb_arb.sv
// tb_cpu7_exu_wb_arb: directed scenarios plus randomized pipeline/LSU traffic against a behavioural model
module tb_cpu7_exu_wb_arb;
  import cpu7_exu_wb_arb_pkg::*;
  localparam int DW = 64;
  localparam int SM = 4;
  logic clk = 1'b0;
  logic reset;
  logic ecl_wb_wen_w, lsu_wb_valid, wb_lsu_ready, lsu_issue_valid_d, ifu_rf_wen_d, wb_ifu_stall_d, wb_irf_wen;
  logic [4:0] ecl_wb_rd_w, lsu_wb_rd, lsu_issue_rd_d, ifu_rs1_d, ifu_rs2_d, ifu_rd_d, wb_irf_rd;
  logic [DW-1:0] ecl_wb_data_w, lsu_wb_data, wb_irf_data;
`ifdef CPU7_WB_ARB_PERF_EN
  logic [31:0] wb_perf_lsu_wait, wb_perf_stall;
`endif
  always #5 clk = ~clk;
  cpu7_exu_wb_arb #(.DW(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .ecl_wb_wen_w(ecl_wb_wen_w), .ecl_wb_rd_w(ecl_wb_rd_w), .ecl_wb_data_w(ecl_wb_data_w),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
    .wb_lsu_ready(wb_lsu_ready),
    .lsu_issue_valid_d(lsu_issue_valid_d), .lsu_issue_rd_d(lsu_issue_rd_d),
    .ifu_rs1_d(ifu_rs1_d), .ifu_rs2_d(ifu_rs2_d), .ifu_rd_d(ifu_rd_d), .ifu_rf_wen_d(ifu_rf_wen_d),
    .wb_ifu_stall_d(wb_ifu_stall_d),
    .wb_irf_wen(wb_irf_wen), .wb_irf_rd(wb_irf_rd), .wb_irf_data(wb_irf_data)
`ifdef CPU7_WB_ARB_PERF_EN
    , .wb_perf_lsu_wait(wb_perf_lsu_wait), .wb_perf_stall(wb_perf_stall)
`endif
  );
  int vecs = 0, errs = 0;
  bit pend[32];
  int wait_n;
  logic m_wen;
  logic [4:0] m_rd;
  logic [DW-1:0] m_data;
  logic [31:0] m_pw, m_ps;
  logic e_ready, e_stall;
  bit e_waiting;
  int e_nw;
  typedef struct { bit v; logic [4:0] rd; logic [DW-1:0] data; } alu_t;
  alu_t pipe[3];
  int d_kind;
  logic [4:0] d_rs1, d_rs2, d_rd;
  logic [4:0] lq[$];
  bit lv;
  logic [DW-1:0] lv_data;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic void model_clear();
    foreach (pend[i]) pend[i] = 0;
    wait_n = 0;
    m_wen = 0;
    m_rd = 0;
    m_data = 0;
    m_pw = 0;
    m_ps = 0;
  endfunction
  function automatic void comb_model();
    bit alu;
    alu = ecl_wb_wen_w && ecl_wb_rd_w != 0;
    e_ready = !reset && !alu;
    e_waiting = lsu_wb_valid && !e_ready;
    e_nw = e_waiting ? ((wait_n + 1 > SM) ? SM : wait_n + 1) : 0;
    e_stall = !reset && (pend[ifu_rs1_d] || pend[ifu_rs2_d] || (ifu_rf_wen_d && pend[ifu_rd_d]) || (e_waiting && e_nw == SM));
  endfunction
  task automatic tick();
    #2;
    comb_model();
    chk("ready", 64'(wb_lsu_ready), 64'(e_ready));
    chk("stall", 64'(wb_ifu_stall_d), 64'(e_stall));
    chk("irf_wen", 64'(wb_irf_wen), 64'(m_wen));
    chk("irf_rd", 64'(wb_irf_rd), 64'(m_rd));
    chk("irf_data", wb_irf_data, m_data);
`ifdef CPU7_WB_ARB_PERF_EN
    chk("perf_wait", 64'(wb_perf_lsu_wait), 64'(m_pw));
    chk("perf_stall", 64'(wb_perf_stall), 64'(m_ps));
`endif
    if (reset) model_clear();
    else begin
      if (ecl_wb_wen_w && ecl_wb_rd_w != 0) begin
        m_wen = 1; m_rd = ecl_wb_rd_w; m_data = ecl_wb_data_w;
      end else if (lsu_wb_valid && lsu_wb_rd != 0) begin
        m_wen = 1; m_rd = lsu_wb_rd; m_data = lsu_wb_data;
      end else begin
        m_wen = 0; m_rd = 0; m_data = 0;
      end
      if (lsu_wb_valid && e_ready) pend[lsu_wb_rd] = 0;
      if (lsu_issue_valid_d && lsu_issue_rd_d != 0) pend[lsu_issue_rd_d] = 1;
      if (e_waiting) m_pw++;
      if (e_stall) m_ps++;
      wait_n = e_nw;
    end
    @(negedge clk);
  endtask
  task automatic idle();
    ecl_wb_wen_w = 0; ecl_wb_rd_w = 0; ecl_wb_data_w = 0;
    lsu_wb_valid = 0; lsu_wb_rd = 0; lsu_wb_data = 0;
    lsu_issue_valid_d = 0; lsu_issue_rd_d = 0;
    ifu_rs1_d = 0; ifu_rs2_d = 0; ifu_rd_d = 0; ifu_rf_wen_d = 0;
  endtask
  function automatic bit in_pipe(input logic [4:0] r);
    foreach (pipe[i]) if (pipe[i].v && pipe[i].rd == r) return 1;
    return 0;
  endfunction
  task automatic gen_d(input int alu_pct);
    int r;
    r = $urandom_range(99);
    d_kind = (r < alu_pct) ? 1 : (r < alu_pct + 15) ? 2 : 0;
    d_rs1 = 5'($urandom); d_rs2 = 5'($urandom); d_rd = 5'($urandom);
    if (d_kind == 2) for (int k = 0; k < 32 && in_pipe(d_rd); k++) d_rd = 5'($urandom);
    if (d_kind == 2 && in_pipe(d_rd)) d_rd = 0;
  endtask
  task automatic pipe_reset();
    foreach (pipe[i]) pipe[i] = '{0, 5'd0, '0};
    lq.delete();
    lv = 0;
  endtask
  logic [31:0] p0;
  bit accepted, stalled;
  int alu_pct;
  initial begin
    reset = 1;
    idle();
    model_clear();
    @(posedge clk);
    @(negedge clk);
    tick();
    tick();
    reset = 0;
    #1;
    chk("s1_rst_wen", 64'(wb_irf_wen), 0);
    chk("s1_rst_rd", 64'(wb_irf_rd), 0);
    chk("s1_rst_data", wb_irf_data, 0);
    chk("s1_rst_stall", 64'(wb_ifu_stall_d), 0);
    ecl_wb_wen_w = 1; ecl_wb_rd_w = 5; ecl_wb_data_w = 'h11;
    tick();
    ecl_wb_wen_w = 0;
    #1;
    chk("s1_wen", 64'(wb_irf_wen), 1);
    chk("s1_rd", 64'(wb_irf_rd), 5);
    chk("s1_data", wb_irf_data, 'h11);
    tick();
    ecl_wb_wen_w = 1; ecl_wb_rd_w = 3; ecl_wb_data_w = 'h33;
    lsu_wb_valid = 1; lsu_wb_rd = 7; lsu_wb_data = 'hAB;
    #1;
    chk("s2_ready0", 64'(wb_lsu_ready), 0);
    tick();
    ecl_wb_wen_w = 0;
    #1;
    chk("s2_ready1", 64'(wb_lsu_ready), 1);
    chk("s2_rd3", 64'(wb_irf_rd), 3);
    tick();
    lsu_wb_valid = 0;
    #1;
    chk("s2_rd7", 64'(wb_irf_rd), 7);
    chk("s2_data", wb_irf_data, 'hAB);
    tick();
    lsu_issue_valid_d = 1; lsu_issue_rd_d = 9;
    tick();
    lsu_issue_valid_d = 0; ifu_rs1_d = 9;
    #1;
    chk("s3_stall", 64'(wb_ifu_stall_d), 1);
    tick();
    tick();
    lsu_wb_valid = 1; lsu_wb_rd = 9; lsu_wb_data = 'h99;
    #1;
    chk("s3_stall_acc", 64'(wb_ifu_stall_d), 1);
    tick();
    lsu_wb_valid = 0;
    #1;
    chk("s3_unstall", 64'(wb_ifu_stall_d), 0);
    chk("s3_pend9", 64'(dut.u_sb.pend[9]), 0);
    tick();
    ifu_rs1_d = 0;
    lsu_issue_valid_d = 1; lsu_issue_rd_d = 9;
    tick();
    lsu_wb_valid = 1; lsu_wb_rd = 9; ifu_rs1_d = 9;
    tick();
    lsu_issue_valid_d = 0; lsu_wb_valid = 0;
    #1;
    chk("s4_stall", 64'(wb_ifu_stall_d), 1);
    chk("s4_pend9", 64'(dut.u_sb.pend[9]), 1);
    tick();
    lsu_wb_valid = 1;
    tick();
    lsu_wb_valid = 0;
    tick();
    ifu_rs1_d = 0;
`ifdef CPU7_WB_ARB_PERF_EN
    p0 = wb_perf_lsu_wait;
`endif
    lsu_wb_valid = 1; lsu_wb_rd = 12; lsu_wb_data = 'hC;
    for (int i = 1; i <= 6; i++) begin
      ecl_wb_wen_w = 1; ecl_wb_rd_w = 5'(i); ecl_wb_data_w = 64'(i);
      #1;
      chk("s5_stall", 64'(wb_ifu_stall_d), (i >= SM) ? 1 : 0);
      tick();
    end
    ecl_wb_wen_w = 0;
    #1;
    chk("s5_ready", 64'(wb_lsu_ready), 1);
    chk("s5_stall_drop", 64'(wb_ifu_stall_d), 0);
    tick();
    lsu_wb_valid = 0;
    tick();
`ifdef CPU7_WB_ARB_PERF_EN
    chk("s6_perf_wait", 64'(wb_perf_lsu_wait - p0), 6);
`endif
    pipe_reset();
    alu_pct = 60;
    gen_d(alu_pct);
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) alu_pct = ($urandom_range(1) != 0) ? 80 : 50;
      reset = (c == 1500 || c == 1501);
      if (reset) begin
        idle();
        pipe_reset();
        tick();
        gen_d(alu_pct);
        continue;
      end
      ecl_wb_wen_w = pipe[2].v; ecl_wb_rd_w = pipe[2].rd; ecl_wb_data_w = pipe[2].data;
      if (!lv && lq.size() > 0 && $urandom_range(1) != 0) begin
        lv = 1;
        lv_data = {$urandom, $urandom};
      end
      lsu_wb_valid = lv; lsu_wb_rd = lv ? lq[0] : 5'd0; lsu_wb_data = lv ? lv_data : '0;
      ifu_rs1_d = d_rs1; ifu_rs2_d = d_rs2; ifu_rd_d = d_rd; ifu_rf_wen_d = (d_kind != 0);
      lsu_issue_valid_d = 0; lsu_issue_rd_d = d_rd;
      comb_model();
      stalled = e_stall;
      accepted = lv && e_ready;
      lsu_issue_valid_d = !stalled && d_kind == 2;
      tick();
      if (accepted) begin
        void'(lq.pop_front());
        lv = 0;
      end
      if (!stalled && d_kind == 2) lq.push_back(d_rd);
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (!stalled && d_kind == 1) ? '{1, d_rd, {$urandom, $urandom}} : '{0, 5'd0, '0};
      if (!stalled) gen_d(alu_pct);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
